seg7_msg_scroller: RTL and testbench
====================================

# seg7_msg_scroller

Message source for the seven-segment letter decoders: holds a short message of 6-bit letter codes and presents a DIGITS-wide window of it, one code per display digit, advancing the window circularly at a prescaled rate. Each digit output feeds one decoder instance directly. A per-digit blank flag lets the top level force a display dark. Codes outside the decoder's defined range are never presented as valid.

## Interface
- DIGITS, 4, number of display digits driven
- DEPTH, 16, message buffer entries (power of two)
- TICK_DIV, 50_000_000, clk cycles per scroll step (≥2)
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  write wr_data into buffer[wr_addr]
- wr_addr  in  log2(DEPTH)  buffer address
- wr_data  in  6  letter code (0=A 1=D 2=E 3=F 4=G 5=H 6=I 7=L 8=T 9=Z)
- len_wr  in  1  load message length from len
- len  in  log2(DEPTH)+1  message length, 0..DEPTH (larger values clamp to DEPTH)
- run  in  1  level; 1 = scrolling enabled
- codes  out  DIGITS*6  digit i code at [6i+5:6i], digit 0 leftmost
- blank  out  DIGITS  1 = digit i must be dark
- wrap  out  1  one-cycle pulse when window position returns to 0

## Operation
- Reset: buffer all entries = 0x3F, msg_len = 0, pos = 0, prescaler = 0, codes = 0, blank = all 1, wrap = 0, state EMPTY.
- Digit i source index: (pos + i) mod msg_len. Digit i blank if msg_len = 0, or i ≥ msg_len while state STATIC, or source code > 9. Blanked digits drive code 0.
- States:
  - EMPTY: msg_len = 0; pos and prescaler held at 0.
  - STATIC: 1 ≤ msg_len ≤ DIGITS; no scrolling, pos held 0, digits 0..msg_len-1 shown.
  - SCROLL: msg_len > DIGITS and run = 1; prescaler counts 0..TICK_DIV-1; on terminal count pos ← pos+1, wrapping from msg_len-1 to 0 with wrap = 1 that cycle.
  - PAUSE: msg_len > DIGITS and run = 0; pos and prescaler hold.
- Transitions are decided solely by msg_len and run each cycle; len_wr moves to the state implied by the new length.
- len_wr: msg_len ← min(len, DEPTH); pos ← 0; prescaler ← 0; overrides a coincident tick (no advance, no wrap).
- wr_en: write always accepted, any address; entries at ≥ msg_len stored but not displayed until length grows.
- wr_en and len_wr in the same cycle: both take effect.
- Reset mid-scroll: everything returns to reset values next edge, buffer included.

## Timing
- All outputs registered.
- codes/blank reflect pos, msg_len and buffer contents from the previous cycle: 1-cycle latency from a write, length load or pos step to the outputs.
- Scroll step period exactly TICK_DIV cycles while run = 1; run low for N cycles stretches that step by exactly N.
- wrap asserts on the same edge pos becomes 0 by stepping; codes show the wrapped window one cycle later.
- First step after len_wr or run rising from reset occurs TICK_DIV cycles later.

## Structure
- Shared package seg7_pkg: CODE_W = 6, letter constants CODE_A..CODE_Z, CODE_MAX = 9, CODE_BLANK = 6'h3F, state enum {EMPTY, STATIC, SCROLL, PAUSE}.
- One sub-module: seg7_tick_prescaler (enable, clear, TICK_DIV parameter, one-cycle tick out).
- Buffer is a flop array (reset-cleared), DIGITS parallel read ports via modulo index.

## Test plan
- Reset, no writes -> blank = 4'b1111, codes = 0, wrap never pulses over 100 cycles.
- TICK_DIV = 4; write H,E,L,L,I (5,2,7,7,6) to 0..4, len = 5, run = 1 -> codes show H E L L, then E L L I, L L I H, L I H E, I H E L every 4 cycles; wrap pulses once on returning to H E L L.
- len = 2 with T,A (8,0) -> STATIC, digits 0-1 = T,A, blank = 4'b1100, pos stays 0 with run = 1.
- Scrolling message, drop run for 7 cycles mid-step -> that step delayed by exactly 7 cycles, pos unchanged during pause.
- Write code 12 into a displayed slot -> that digit blank = 1 and code 0 one cycle later; len = 20 -> msg_len = 16.
- len_wr coincident with prescaler terminal count -> pos = 0, no wrap pulse; reset asserted mid-scroll -> reset values next cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared letter codes, limits and scroller state encoding for the seven-segment message path.
package seg7_pkg;

   localparam int unsigned CODE_W = 6;

   localparam logic [CODE_W-1:0] CODE_A     = 6'd0;
   localparam logic [CODE_W-1:0] CODE_D     = 6'd1;
   localparam logic [CODE_W-1:0] CODE_E     = 6'd2;
   localparam logic [CODE_W-1:0] CODE_F     = 6'd3;
   localparam logic [CODE_W-1:0] CODE_G     = 6'd4;
   localparam logic [CODE_W-1:0] CODE_H     = 6'd5;
   localparam logic [CODE_W-1:0] CODE_I     = 6'd6;
   localparam logic [CODE_W-1:0] CODE_L     = 6'd7;
   localparam logic [CODE_W-1:0] CODE_T     = 6'd8;
   localparam logic [CODE_W-1:0] CODE_Z     = 6'd9;
   localparam logic [CODE_W-1:0] CODE_MAX   = 6'd9;
   localparam logic [CODE_W-1:0] CODE_BLANK = 6'h3F;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      STATIC = 2'd1,
      SCROLL = 2'd2,
      PAUSE  = 2'd3
   } state_e;

   function automatic logic code_valid(input logic [CODE_W-1:0] c);
      return c <= CODE_MAX;
   endfunction

endpackage

// File: rtl/seg7_tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV enabled cycles; clear restarts the count.
module seg7_tick_prescaler #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      tick    = enable && !clear && (count_q == LAST);
      count_d = count_q;
      if (clear)       count_d = '0;
      else if (tick)   count_d = '0;
      else if (enable) count_d = count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) count_q <= '0;
      else       count_q <= count_d;
   end

endmodule

// File: rtl/seg7_msg_scroller.sv
// Message buffer presenting a circularly scrolling DIGITS-wide window of letter codes.
module seg7_msg_scroller
   import seg7_pkg::*;
#(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [$clog2(DEPTH)-1:0]     wr_addr,
   input  logic [CODE_W-1:0]            wr_data,
   input  logic                         len_wr,
   input  logic [$clog2(DEPTH):0]       len,
   input  logic                         run,
   output logic [DIGITS*CODE_W-1:0]     codes,
   output logic [DIGITS-1:0]            blank,
   output logic                         wrap
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned SW = AW + 2;

   logic [CODE_W-1:0]        msg_buf_q [DEPTH];
   logic [LW-1:0]            msg_len_q, len_clamped;
   logic [AW-1:0]            pos_q, pos_d;
   logic                     wrap_d, tick;
   state_e                   state;
   logic [DIGITS*CODE_W-1:0] codes_d;
   logic [DIGITS-1:0]        blank_d;
   logic [SW-1:0]            src_idx [DIGITS];
   logic [CODE_W-1:0]        src_code [DIGITS];

   assign len_clamped = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;

   always_comb begin
      if (msg_len_q == '0)               state = EMPTY;
      else if (msg_len_q <= LW'(DIGITS)) state = STATIC;
      else if (run)                      state = SCROLL;
      else                               state = PAUSE;
   end

   seg7_tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .enable (state == SCROLL),
      .clear  (len_wr || state == EMPTY || state == STATIC),
      .tick   (tick)
   );

   // A length load wins over a coincident tick: no step and no wrap.
   always_comb begin
      pos_d  = pos_q;
      wrap_d = 1'b0;
      if (len_wr || state == EMPTY || state == STATIC) begin
         pos_d = '0;
      end else if (tick) begin
         if ({1'b0, pos_q} == msg_len_q - LW'(1)) begin
            pos_d  = '0;
            wrap_d = 1'b1;
         end else begin
            pos_d = pos_q + 1'b1;
         end
      end
   end

   // pos < msg_len and i < DIGITS < msg_len while scrolling, so one subtract is a full modulo.
   always_comb begin
      codes_d = '0;
      blank_d = '0;
      for (int i = 0; i < DIGITS; i++) begin
         src_idx[i] = SW'(pos_q) + SW'(i);
         if (src_idx[i] >= SW'(msg_len_q)) src_idx[i] = src_idx[i] - SW'(msg_len_q);
         src_code[i] = msg_buf_q[src_idx[i][AW-1:0]];
         blank_d[i]  = (msg_len_q == '0) || (state == STATIC && LW'(i) >= msg_len_q) ||
                       !code_valid(src_code[i]);
         codes_d[i*CODE_W +: CODE_W] = blank_d[i] ? '0 : src_code[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) msg_buf_q[k] <= CODE_BLANK;
         msg_len_q <= '0;
         pos_q     <= '0;
         codes     <= '0;
         blank     <= '1;
         wrap      <= 1'b0;
      end else begin
         if (wr_en)  msg_buf_q[wr_addr] <= wr_data;
         if (len_wr) msg_len_q <= len_clamped;
         pos_q <= pos_d;
         wrap  <= wrap_d;
         codes <= codes_d;
         blank <= blank_d;
      end
   end

endmodule

// File: tb/tb_seg7_msg_scroller.sv
// Cycle-level scoreboard bench for seg7_msg_scroller with a fast prescaler.
module tb_seg7_msg_scroller;

   localparam int DIGITS   = 4;
   localparam int DEPTH    = 16;
   localparam int TICK_DIV = 4;

   logic        clk = 1'b0;
   logic        reset, wr_en, len_wr, run;
   logic [3:0]  wr_addr;
   logic [5:0]  wr_data;
   logic [4:0]  len;
   logic [23:0] codes;
   logic [3:0]  blank;
   logic        wrap;

   typedef struct packed {
      logic [23:0] codes;
      logic [3:0]  blank;
      logic        wrap;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   m_buf[DEPTH];
   int   m_len, m_pos, m_cnt;
   int   wrap_seen;

   seg7_msg_scroller #(
      .DIGITS   (DIGITS),
      .DEPTH    (DEPTH),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .len_wr  (len_wr),
      .len     (len),
      .run     (run),
      .codes   (codes),
      .blank   (blank),
      .wrap    (wrap)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Predict the outputs after the next edge, step the model, then compare.
   task automatic cyc();
      exp_t e;
      int   src;
      e = '{codes: 24'd0, blank: 4'hF, wrap: 1'b0};
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) m_buf[k] = 63;
         m_len = 0;
         m_pos = 0;
         m_cnt = 0;
      end else begin
         for (int i = 0; i < DIGITS; i++) begin
            if (m_len == 0) begin
               e.blank[i] = 1'b1;
            end else begin
               src = m_buf[(m_pos + i) % m_len];
               e.blank[i] = (m_len <= DIGITS && i >= m_len) || src > 9;
               if (!e.blank[i]) e.codes[i*6 +: 6] = 6'(src);
            end
         end
         if (len_wr) begin
            m_len = (len > 16) ? 16 : int'(len);
            m_pos = 0;
            m_cnt = 0;
         end else if (m_len > DIGITS) begin
            if (run) begin
               if (m_cnt == TICK_DIV - 1) begin
                  m_cnt = 0;
                  if (m_pos == m_len - 1) begin
                     m_pos  = 0;
                     e.wrap = 1'b1;
                  end else begin
                     m_pos++;
                  end
               end else begin
                  m_cnt++;
               end
            end
         end else begin
            m_pos = 0;
            m_cnt = 0;
         end
         if (wr_en) m_buf[wr_addr] = int'(wr_data);
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_eq("codes", 32'(codes), 32'(e.codes));
      check_eq("blank", 32'(blank), 32'(e.blank));
      check_eq("wrap", 32'(wrap), 32'(e.wrap));
      if (wrap === 1'b1) wrap_seen++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc();
   endtask

   task automatic wr(input int a, input int d);
      wr_en   = 1'b1;
      wr_addr = 4'(a);
      wr_data = 6'(d);
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic setlen(input int l);
      len_wr = 1'b1;
      len    = 5'(l);
      cyc();
      len_wr = 1'b0;
   endtask

   initial begin
      int guard;
      reset = 1'b1; wr_en = 1'b0; len_wr = 1'b0; run = 1'b0;
      wr_addr = '0; wr_data = '0; len = '0;
      idle(2);
      reset = 1'b0;
      wrap_seen = 0;
      idle(100);
      check_eq("idle_wraps", 32'(wrap_seen), 32'd0);

      // HELLO scroll
      wr(0, 5); wr(1, 2); wr(2, 7); wr(3, 7); wr(4, 6);
      run = 1'b1;
      setlen(5);
      wrap_seen = 0;
      cyc();
      check_eq("hell_first", 32'(codes), {8'd0, 6'd7, 6'd7, 6'd2, 6'd5});
      idle(19);
      check_eq("one_wrap", 32'(wrap_seen), 32'd1);
      cyc();
      check_eq("hell_again", 32'(codes), {8'd0, 6'd7, 6'd7, 6'd2, 6'd5});

      // Pause mid-step
      idle(2);
      run = 1'b0;
      idle(7);
      run = 1'b1;
      idle(12);

      // Invalid code in a displayed slot
      wr(1, 12);
      idle(10);

      // Static two-letter message; write and length load together
      wr(0, 8);
      wr_en = 1'b1; wr_addr = 4'd1; wr_data = 6'd0;
      len_wr = 1'b1; len = 5'd2;
      cyc();
      wr_en = 1'b0; len_wr = 1'b0;
      idle(12);
      check_eq("static_blank", 32'(blank), 32'hC);
      check_eq("static_codes", 32'(codes), {8'd0, 12'd0, 6'd0, 6'd8});

      // Clamped length
      for (int a = 5; a < 12; a++) wr(a, a % 10);
      setlen(20);
      idle(70);

      // Length load coincident with the terminal tick at the last position
      guard = 0;
      while (!(m_len > DIGITS && m_cnt == TICK_DIV - 1 && m_pos == m_len - 1) && guard < 200) begin
         cyc();
         guard++;
      end
      check_eq("reach_terminal", 32'(guard < 200), 32'd1);
      setlen(16);
      check_eq("no_wrap_on_load", 32'(wrap), 32'd0);
      idle(10);

      // Reset mid-scroll clears the buffer too
      idle(6);
      reset = 1'b1;
      cyc();
      check_eq("reset_blank", 32'(blank), 32'hF);
      reset = 1'b0;
      setlen(5);
      idle(3);
      check_eq("cleared_buffer", 32'(blank), 32'hF);
      idle(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
